uart_rx_arbiter: RTL and testbench

UART_RX_ARBITER -- requirements
Module: uart_rx_arbiter

---
 rtl/uart_rx_arbiter.sv | 69 ++++++
 tb/tb_uart_rx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_arbiter.sv
// uart_rx_arbiter: round-robin merge of UART receive channels into a shared show-ahead FIFO tagged with source index
module uart_rx_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [8*NUM_CH-1:0]       ch_data,
  output logic [NUM_CH-1:0]         ch_ready,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic                      flush,
  output logic [9:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_pop,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [9:0]        mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [AW:0]       fill_q;
  logic [CW-1:0]     last_grant, gnt, idx;
  logic [NUM_CH-1:0] req;
  logic              found, push, pop;
  assign req = ch_valid & ch_enable;
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(last_grant) + k) % NUM_CH);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end
  // reset gates ready so nothing is accepted while the FIFO is being discarded
  assign ch_ready  = (found && !full && !flush && !reset) ? NUM_CH'(1) << gnt : '0;
  assign push      = |ch_ready;
  assign pop       = out_pop && out_valid && !flush;
  assign fill      = fill_q;
  assign full      = fill_q == (AW+1)'(DEPTH);
  assign out_valid = |fill_q;
  assign out_data  = out_valid ? mem[head] : '0;
  always_ff @(posedge clk)
    if (push) mem[tail] <= {2'(gnt), ch_data[gnt*8 +: 8]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      fill_q     <= '0;
      last_grant <= CW'(NUM_CH - 1);
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      fill_q <= '0;
    end else begin
      if (push) begin
        tail       <= tail + 1'b1;
        last_grant <= gnt;
      end
      if (pop) head <= head + 1'b1;
      fill_q <= (push && !pop) ? fill_q + 1'b1 : (!push && pop) ? fill_q - 1'b1 : fill_q;
    end
  end
endmodule

// File: tb/tb_uart_rx_arbiter.sv
// tb_uart_rx_arbiter: scoreboard-driven scenario tests for uart_rx_arbiter
module tb_uart_rx_arbiter;
  logic        clk = 0;
  logic        reset = 1;
  logic [3:0]  ch_valid = '0;
  logic [31:0] ch_data = '0;
  logic [3:0]  ch_ready;
  logic [3:0]  ch_enable = 4'hF;
  logic        flush = 0;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_pop = 0;
  logic [4:0]  fill;
  logic        full;
  logic [9:0]  sb[$];
  logic [9:0]  exp_d;
  int          passed = 0;
  int          total = 0;

  uart_rx_arbiter #(.NUM_CH(4), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .ch_enable(ch_enable), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_pop(out_pop),
    .fill(fill), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ch_valid = 4'hF;
    #3;
    total++; if (ch_ready !== 4'b0) $display("FAIL reset_ready got %b want 0000", ch_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 10'h0) $display("FAIL reset_data got %h want 000", out_data); else passed++;
    total++; if (fill !== 5'd0) $display("FAIL reset_fill got %0d want 0", fill); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passed++;
    tick; tick;
    reset = 0;
  endtask

  task automatic test_rr_fairness;
    ch_valid = 4'hF;
    ch_data = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (ch_ready !== 4'(1 << k)) $display("FAIL rr_ready[%0d] got %b want %b", k, ch_ready, 4'(1 << k)); else passed++;
      sb.push_back({2'(k), 8'h00});
      tick;
    end
    ch_valid = '0;
    #1;
    total++; if (fill !== 5'd4) $display("FAIL rr_fill got %0d want 4", fill); else passed++;
    out_pop = 1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) begin
      exp_d = sb.pop_front();
      total++; if (!out_valid || out_data !== exp_d) $display("FAIL rr_order got %h/%b want %h/1", out_data, out_valid, exp_d); else passed++;
      tick;
    end
    out_pop = 0;
  endtask

  task automatic test_rotation;
    ch_valid = 4'b0100;
    ch_data = 32'h33_22_11_30;
    #1;
    total++; if (ch_ready !== 4'b0100) $display("FAIL rot_ch2 got %b want 0100", ch_ready); else passed++;
    sb.push_back({2'd2, 8'h22});
    tick;
    ch_valid = 4'b1001;
    #1;
    total++; if (ch_ready !== 4'b1000) $display("FAIL rot_ch3_first got %b want 1000", ch_ready); else passed++;
    sb.push_back({2'd3, 8'h33});
    tick;
    total++; if (ch_ready !== 4'b0001) $display("FAIL rot_ch0_second got %b want 0001", ch_ready); else passed++;
    sb.push_back({2'd0, 8'h30});
    tick;
    ch_valid = '0;
    out_pop = 1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) begin
      exp_d = sb.pop_front();
      total++; if (!out_valid || out_data !== exp_d) $display("FAIL rot_order got %h/%b want %h/1", out_data, out_valid, exp_d); else passed++;
      tick;
    end
    out_pop = 0;
  endtask

  task automatic test_full_backpressure;
    ch_valid = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      ch_data[15:8] = 8'(k);
      #1;
      total++; if (ch_ready !== 4'b0010) $display("FAIL full_push[%0d] got %b want 0010", k, ch_ready); else passed++;
      sb.push_back({2'd1, 8'(k)});
      tick;
    end
    ch_data[15:8] = 8'hAA;
    #1;
    total++; if (full !== 1'b1 || fill !== 5'd16) $display("FAIL full_flag got %b/%0d want 1/16", full, fill); else passed++;
    total++; if (ch_ready !== 4'b0) $display("FAIL full_ready got %b want 0000", ch_ready); else passed++;
    tick;
    total++; if (ch_ready !== 4'b0) $display("FAIL full_hold got %b want 0000", ch_ready); else passed++;
    out_pop = 1;
    #1;
    total++; if (ch_ready !== 4'b0) $display("FAIL full_ready_pop got %b want 0000", ch_ready); else passed++;
    exp_d = sb.pop_front();
    total++; if (out_data !== exp_d) $display("FAIL full_pop_head got %h want %h", out_data, exp_d); else passed++;
    tick;
    out_pop = 0;
    #1;
    total++; if (ch_ready !== 4'b0010) $display("FAIL full_accept_aa got %b want 0010", ch_ready); else passed++;
    sb.push_back({2'd1, 8'hAA});
    tick;
    ch_valid = '0;
    #1;
    total++; if (fill !== 5'd16) $display("FAIL full_refill got %0d want 16", fill); else passed++;
    out_pop = 1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) begin
      exp_d = sb.pop_front();
      total++; if (!out_valid || out_data !== exp_d) $display("FAIL full_order got %h/%b want %h/1", out_data, out_valid, exp_d); else passed++;
      tick;
    end
    out_pop = 0;
  endtask

  task automatic test_push_pop;
    ch_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      ch_data[7:0] = 8'h50 + 8'(k);
      #1;
      total++; if (ch_ready !== 4'b0001) $display("FAIL pp_fill[%0d] got %b want 0001", k, ch_ready); else passed++;
      sb.push_back({2'd0, 8'h50 + 8'(k)});
      tick;
    end
    ch_valid = 4'b1000;
    ch_data[31:24] = 8'h55;
    out_pop = 1;
    #1;
    total++; if (fill !== 5'd5) $display("FAIL pp_fill_before got %0d want 5", fill); else passed++;
    total++; if (ch_ready !== 4'b1000) $display("FAIL pp_ready got %b want 1000", ch_ready); else passed++;
    exp_d = sb.pop_front();
    total++; if (out_data !== exp_d) $display("FAIL pp_head got %h want %h", out_data, exp_d); else passed++;
    sb.push_back({2'd3, 8'h55});
    tick;
    ch_valid = '0;
    out_pop = 0;
    #1;
    total++; if (fill !== 5'd5) $display("FAIL pp_fill_after got %0d want 5", fill); else passed++;
    total++; if (out_data !== sb[0]) $display("FAIL pp_advance got %h want %h", out_data, sb[0]); else passed++;
    out_pop = 1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) begin
      exp_d = sb.pop_front();
      total++; if (!out_valid || out_data !== exp_d) $display("FAIL pp_order got %h/%b want %h/1", out_data, out_valid, exp_d); else passed++;
      tick;
    end
    out_pop = 0;
  endtask

  task automatic test_mask_flush;
    ch_enable = 4'b1011;
    ch_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (ch_ready !== 4'b0) $display("FAIL mask_ch2[%0d] got %b want 0000", k, ch_ready); else passed++;
      tick;
    end
    ch_valid = 4'b0101;
    for (int k = 0; k < 7; k++) begin
      ch_data[7:0] = 8'h70 + 8'(k);
      #1;
      total++; if (ch_ready !== 4'b0001) $display("FAIL mask_ch0[%0d] got %b want 0001", k, ch_ready); else passed++;
      tick;
    end
    ch_valid = 4'b0001;
    flush = 1;
    out_pop = 1;
    #1;
    total++; if (fill !== 5'd7) $display("FAIL flush_fill_before got %0d want 7", fill); else passed++;
    total++; if (ch_ready !== 4'b0) $display("FAIL flush_ready got %b want 0000", ch_ready); else passed++;
    tick;
    flush = 0;
    out_pop = 0;
    ch_valid = '0;
    #1;
    total++; if (fill !== 5'd0 || out_valid !== 1'b0 || out_data !== 10'h0)
      $display("FAIL flush_clear got %0d/%b/%h want 0/0/000", fill, out_valid, out_data); else passed++;
    ch_enable = 4'hF;
  endtask

  task automatic test_reset_wrap;
    int sent;
    int got;
    logic [7:0] b;
    logic [4:0] mf;
    ch_valid = 4'b1000;
    for (int k = 0; k < 9; k++) begin
      ch_data[31:24] = 8'h90 + 8'(k);
      #1;
      total++; if (ch_ready !== 4'b1000) $display("FAIL rw_fill[%0d] got %b want 1000", k, ch_ready); else passed++;
      tick;
    end
    total++; if (fill !== 5'd9) $display("FAIL rw_fill9 got %0d want 9", fill); else passed++;
    reset = 1;
    #1;
    total++; if (fill !== 5'd0 || out_valid !== 1'b0 || out_data !== 10'h0 || full !== 1'b0 || ch_ready !== 4'b0)
      $display("FAIL rw_async_reset got fill=%0d v=%b d=%h f=%b r=%b want 0", fill, out_valid, out_data, full, ch_ready); else passed++;
    sb.delete();
    ch_valid = '0;
    tick;
    reset = 0;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 800 && got < 40; cyc++) begin
      b = 8'(sent * 7 + 3);
      ch_valid = (sent < 40) ? 4'b0100 : 4'b0000;
      ch_data[23:16] = b;
      out_pop = 1'($urandom_range(0, 1));
      #1;
      mf = 5'(sb.size());
      total++; if (fill !== mf) $display("FAIL wrap_fill got %0d want %0d", fill, mf); else passed++;
      total++; if (ch_ready !== ((sent < 40 && mf < 16) ? 4'b0100 : 4'b0000))
        $display("FAIL wrap_ready got %b (sent %0d, fill %0d)", ch_ready, sent, mf); else passed++;
      if (out_pop && out_valid) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
        total++; if (out_data !== exp_d) $display("FAIL wrap_order got %h want %h", out_data, exp_d); else passed++;
        got++;
      end
      if (ch_ready[2]) begin
        sb.push_back({2'd2, b});
        sent++;
      end
      tick;
    end
    ch_valid = '0;
    out_pop = 0;
    #1;
    total++; if (got !== 40 || fill !== 5'd0) $display("FAIL wrap_done got %0d popped fill %0d want 40/0", got, fill); else passed++;
  endtask

  initial begin
    test_reset;
    test_rr_fairness;
    test_rotation;
    test_full_backpressure;
    test_push_pop;
    test_mask_flush;
    test_reset_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
